// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the network controllers.
//   hl_state_t    : hidden-layer sequencer states
//   HIDDEN_PASSES : passes needed to cover the 20 hidden neurons
//   MACS_PER_PASS : parallel MAC units (neurons evaluated per pass)
//   cnt_width()   : bits needed for a counter that must hold max_val
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ISSUE,
    DRAIN,
    LOAD,
    DONE
  } hl_state_t;

  localparam int HIDDEN_PASSES = 2;
  localparam int MACS_PER_PASS = 10;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hidden_layer_ctrl.sv
// Hidden-layer sequencer: runs the 10 MAC units over all inputs twice,
// loading hidden regs 1-10 after pass 0 and 11-20 after pass 1.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin one evaluation (honoured only in IDLE)
//   in_valid  : input/weight data for the current address is present
//   busy      : high in every state except IDLE
//   in_addr   : input memory address (idx)
//   wgt_addr  : weight row address (pass*N_INPUTS + idx)
//   acc_clr   : clear all accumulators
//   mac_en    : accumulate current product (in_valid while issuing)
//   ld1, ld2  : load hidden regs 1-10 / 11-20
//   done      : one-cycle completion pulse
module hidden_layer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int N_INPUTS = 62,
  parameter int MAC_LAT  = 2,
  parameter int IDX_W    = 6,
  parameter int WADDR_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               busy,
  output logic [IDX_W-1:0]   in_addr,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic               acc_clr,
  output logic               mac_en,
  output logic               ld1,
  output logic               ld2,
  output logic               done
);

  localparam int                 DRAIN_W    = cnt_width(MAC_LAT);
  localparam int                 DRAIN_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_INPUTS - 1);
  localparam logic [WADDR_W-1:0] PASS_OFS   = WADDR_W'(N_INPUTS);

  hl_state_t          state, state_nxt;
  logic               pass;
  logic [IDX_W-1:0]   idx;
  logic [DRAIN_W-1:0] drain_cnt;

  logic idx_last;
  logic last_pass;

  assign idx_last  = (idx == IDX_LAST);
  assign last_pass = (pass == 1'(HIDDEN_PASSES - 1));

  // NOTE: every state register uses non-blocking assignment so all flops
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pass      <= 1'b0;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) pass <= 1'b0;
        CLR:  idx <= '0;
        ISSUE: begin
          if (in_valid) begin
            if (idx_last) drain_cnt <= '0;
            else          idx       <= idx + 1'b1;
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        LOAD:  if (!last_pass) pass <= 1'b1;
        DONE: begin
          pass <= 1'b0;
          idx  <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: each output and the next state get a default before the case so
  // no path through this block leaves a value unassigned (no latches).
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    ld1       = 1'b0;
    ld2       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CLR;
      CLR: begin
        acc_clr   = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        mac_en = in_valid;
        if (in_valid && idx_last)
          state_nxt = (MAC_LAT == 0) ? LOAD : DRAIN;
      end
      DRAIN: if (drain_cnt == DRAIN_W'(DRAIN_LAST)) state_nxt = LOAD;
      LOAD: begin
        ld1       = !last_pass;
        ld2       = last_pass;
        state_nxt = last_pass ? DONE : CLR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses come straight from the counters; the pass offset is a constant.
  assign in_addr  = idx;
  assign wgt_addr = pass ? (PASS_OFS + WADDR_W'(idx)) : WADDR_W'(idx);

endmodule

// File: tb/tb_hidden_layer_ctrl.sv
// Self-checking bench for hidden_layer_ctrl. Two instances: the default
// configuration and a small one (N_INPUTS=4, MAC_LAT=0). For each run an
// expected per-cycle output timeline is built from the sequencing rules
// (clear, N accepted inputs with stalls, drain, load; twice; then done)
// and compared with the selected instance every cycle.
module tb_hidden_layer_ctrl;

  localparam int MAXC = 320;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, sel;

  // default instance
  logic       b_busy, b_acc_clr, b_mac_en, b_ld1, b_ld2, b_done;
  logic [5:0] b_in_addr;
  logic [6:0] b_wgt_addr;
  // small instance
  logic       s_busy, s_acc_clr, s_mac_en, s_ld1, s_ld2, s_done;
  logic [5:0] s_in_addr;
  logic [6:0] s_wgt_addr;

  hidden_layer_ctrl dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid),
    .busy(b_busy), .in_addr(b_in_addr), .wgt_addr(b_wgt_addr),
    .acc_clr(b_acc_clr), .mac_en(b_mac_en), .ld1(b_ld1), .ld2(b_ld2),
    .done(b_done)
  );

  hidden_layer_ctrl #(.N_INPUTS(4), .MAC_LAT(0), .IDX_W(6), .WADDR_W(7)) dut_s (
    .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid),
    .busy(s_busy), .in_addr(s_in_addr), .wgt_addr(s_wgt_addr),
    .acc_clr(s_acc_clr), .mac_en(s_mac_en), .ld1(s_ld1), .ld2(s_ld2),
    .done(s_done)
  );

  logic [18:0] b_vec, s_vec, obs;
  assign b_vec = {b_busy, b_acc_clr, b_mac_en, b_ld1, b_ld2, b_done, b_wgt_addr, b_in_addr};
  assign s_vec = {s_busy, s_acc_clr, s_mac_en, s_ld1, s_ld2, s_done, s_wgt_addr, s_in_addr};
  assign obs   = sel ? s_vec : b_vec;

  int total = 0;
  int bad   = 0;

  bit          iv [MAXC];
  bit          st [MAXC];
  logic [18:0] exp_row [MAXC];

  // per-run observations
  int first_ld1, first_ld2, first_done;
  int n_mac, n_clr, n_ld1, n_ld2, n_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] row(input bit busy_v, input bit clr_v, input bit mac_v,
                                      input bit l1_v, input bit l2_v, input bit dn_v,
                                      input int wgt, input int addr);
    return {busy_v, clr_v, mac_v, l1_v, l2_v, dn_v, 7'(wgt), 6'(addr)};
  endfunction

  // Expected timeline: row 0 is the IDLE cycle in which start is sampled.
  task automatic build_expect(input int n, input int lat, input int rst_at);
    int t;
    for (int c = 0; c < MAXC; c++) exp_row[c] = '0;
    t = 1;
    for (int p = 0; p < 2; p++) begin
      // during the clear cycle idx still holds its previous value
      if (t < MAXC) exp_row[t] = row(1, 1, 0, 0, 0, 0, p * n + (p == 0 ? 0 : n - 1),
                                     (p == 0 ? 0 : n - 1));
      t++;
      for (int k = 0; k < n; k++) begin
        while (t < MAXC && !iv[t]) begin
          exp_row[t] = row(1, 0, 0, 0, 0, 0, p * n + k, k);
          t++;
        end
        if (t < MAXC) exp_row[t] = row(1, 0, 1, 0, 0, 0, p * n + k, k);
        t++;
      end
      for (int d = 0; d < lat; d++) begin
        if (t < MAXC) exp_row[t] = row(1, 0, 0, 0, 0, 0, p * n + n - 1, n - 1);
        t++;
      end
      if (t < MAXC) exp_row[t] = row(1, 0, 0, p == 0, p == 1, 0, p * n + n - 1, n - 1);
      t++;
    end
    if (t < MAXC) exp_row[t] = row(1, 0, 0, 0, 0, 1, 2 * n - 1, n - 1);
    if (rst_at >= 0)
      for (int c = rst_at + 1; c < MAXC; c++) exp_row[c] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drive one run of len cycles; called right after a rising edge.
  task automatic run(input bit s, input int n, input int lat, input int len,
                     input int rst_at, input string name);
    sel = s;
    do_reset();
    build_expect(n, lat, rst_at);
    first_ld1 = -1; first_ld2 = -1; first_done = -1;
    n_mac = 0; n_clr = 0; n_ld1 = 0; n_ld2 = 0; n_done = 0;
    for (int c = 0; c < len; c++) begin
      start    = (c == 0) || st[c];
      in_valid = iv[c];
      rst      = (c == rst_at);
      @(negedge clk);
      check($sformatf("%s_c%0d", name, c), 32'(obs), 32'(exp_row[c]));
      if (obs[16]) n_mac++;
      if (obs[17]) n_clr++;
      if (obs[15]) begin n_ld1++;  if (first_ld1  < 0) first_ld1  = c; end
      if (obs[14]) begin n_ld2++;  if (first_ld2  < 0) first_ld2  = c; end
      if (obs[13]) begin n_done++; if (first_done < 0) first_done = c; end
      @(posedge clk);
      #1;
    end
    start = 1'b0; rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic clear_stim(input bit iv_val);
    for (int c = 0; c < MAXC; c++) begin
      iv[c] = iv_val;
      st[c] = 1'b0;
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_default", 32'(b_vec), 32'd0);
    check("reset_small", 32'(s_vec), 32'd0);
    @(posedge clk); #1;

    // 1: defaults, in_valid always high
    clear_stim(1'b1);
    run(1'b0, 62, 2, 140, -1, "nominal");
    check("nom_ld1_cyc", 32'(first_ld1), 32'd66);
    check("nom_ld2_cyc", 32'(first_ld2), 32'd132);
    check("nom_done_cyc", 32'(first_done), 32'd133);
    check("nom_mac_cnt", 32'(n_mac), 32'd124);
    check("nom_clr_cnt", 32'(n_clr), 32'd2);

    // 2: three stall cycles while idx=10 in pass 0 (idx k issues in cycle 2+k)
    clear_stim(1'b1);
    iv[12] = 1'b0; iv[13] = 1'b0; iv[14] = 1'b0;
    run(1'b0, 62, 2, 145, -1, "stall");
    check("stall_ld1_cyc", 32'(first_ld1), 32'd69);
    check("stall_done_cyc", 32'(first_done), 32'd136);
    check("stall_mac_cnt", 32'(n_mac), 32'd124);

    // 3: start re-asserted while busy, including the DONE cycle
    clear_stim(1'b1);
    st[5] = 1'b1; st[70] = 1'b1; st[133] = 1'b1;
    run(1'b0, 62, 2, 145, -1, "restart");
    check("restart_ld1_n", 32'(n_ld1), 32'd1);
    check("restart_ld2_n", 32'(n_ld2), 32'd1);
    check("restart_done_n", 32'(n_done), 32'd1);

    // 4: reset in cycle 80 (pass 1 issue), then a fresh run
    clear_stim(1'b1);
    run(1'b0, 62, 2, 140, 80, "abort");
    check("abort_ld1_n", 32'(n_ld1), 32'd1);
    check("abort_ld2_n", 32'(n_ld2), 32'd0);
    check("abort_done_n", 32'(n_done), 32'd0);
    run(1'b0, 62, 2, 140, -1, "fresh");
    check("fresh_done_cyc", 32'(first_done), 32'd133);

    // 5: random in_valid, default config
    for (int r = 0; r < 3; r++) begin
      clear_stim(1'b0);
      for (int c = 0; c < MAXC; c++) iv[c] = ($urandom_range(3) != 0);
      run(1'b0, 62, 2, MAXC, -1, $sformatf("rnd%0d", r));
      check("rnd_mac_cnt", 32'(n_mac), 32'd124);
      check("rnd_clr_cnt", 32'(n_clr), 32'd2);
      check("rnd_done_n", 32'(n_done), 32'd1);
    end

    // 6: small config, no drain
    clear_stim(1'b1);
    run(1'b1, 4, 0, 20, -1, "small");
    check("small_ld1_cyc", 32'(first_ld1), 32'd6);
    check("small_ld2_cyc", 32'(first_ld2), 32'd12);
    check("small_done_cyc", 32'(first_done), 32'd13);
    check("small_mac_cnt", 32'(n_mac), 32'd8);

    for (int r = 0; r < 4; r++) begin
      clear_stim(1'b0);
      for (int c = 0; c < MAXC; c++) iv[c] = ($urandom_range(2) != 0);
      run(1'b1, 4, 0, 60, -1, $sformatf("srnd%0d", r));
      check("srnd_mac_cnt", 32'(n_mac), 32'd8);
      check("srnd_done_n", 32'(n_done), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hidden_layer_ctrl.md
Name: hidden_layer_ctrl

Overview:
- FSM that sequences the 20-neuron hidden layer: 10 parallel MAC units, each pass running over all N_INPUTS inputs, in two passes.
- Drives input and weight memory addresses, accumulator clear and MAC enable.
- Asserts ld1 after pass 0 (hidden regs 1-10) and ld2 after pass 1 (hidden regs 11-20), then pulses done.
- Sits between the top-level network controller (start/done) and the hidden datapath (MACs, hidden register bank).

Parameters:
- N_INPUTS, 62, inputs per neuron; legal range 1..2^IDX_W.
- MAC_LAT, 2, MAC pipeline depth in cycles from mac_en to a valid accumulator result; 0 legal.
- IDX_W, 6, input index width.
- WADDR_W, 7, weight address width; must hold 2*N_INPUTS-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one hidden-layer evaluation; sampled only in IDLE.
- in_valid  in  1  input/weight data for the current address is available this cycle.
- busy  out  1  high in every state except IDLE.
- in_addr  out  IDX_W  input memory address = idx.
- wgt_addr  out  WADDR_W  weight row address = pass*N_INPUTS + idx.
- acc_clr  out  1  clear all 10 accumulators.
- mac_en  out  1  accumulate the current product.
- ld1  out  1  load hidden regs 1-10.
- ld2  out  1  load hidden regs 11-20.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Registers: state, pass (1 bit), idx (IDX_W), drain_cnt (sized to hold MAC_LAT).
- Outputs are decoded from registers only (Moore). Sole exception: mac_en = in_valid while in ISSUE.
- Reset: state=IDLE, pass=0, idx=0, drain_cnt=0. All outputs 0, including both addresses.
- rst is asserted mid-operation: abort on that edge and return to IDLE. No ld/done pulse is issued. Hidden registers keep their contents; the controller does not reset them.
- IDLE: busy=0. start=1 -> CLR with pass=0.
- CLR: acc_clr=1 for exactly one cycle. Set idx=0 -> ISSUE.
- ISSUE: addresses are valid.
  - in_valid=0: stall. idx, addresses and state hold; mac_en=0.
  - in_valid=1 and idx<N_INPUTS-1: idx increments.
  - in_valid=1 and idx==N_INPUTS-1: clear drain_cnt -> DRAIN, or -> LOAD directly if MAC_LAT==0.
- DRAIN: mac_en=0 and addresses hold their last value. Stay until drain_cnt==MAC_LAT-1 -> LOAD, i.e. exactly MAC_LAT cycles.
- LOAD: exactly one cycle; ld1=1 if pass==0, else ld2=1. ld1 and ld2 are never high together.
  - pass==0: set pass=1 -> CLR.
  - pass==1: -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE. pass and idx reset to 0.
- start while busy, including the DONE cycle: ignored, not queued.
- Latency with in_valid held 1:
  - Each pass = 1 (CLR) + N_INPUTS (ISSUE) + MAC_LAT (DRAIN) + 1 (LOAD) cycles.
  - done is high during cycle 2*(N_INPUTS+MAC_LAT+2)+1, counting the IDLE cycle in which start is sampled as cycle 0.
  - Defaults: done in cycle 133, ld1 in cycle 66, ld2 in cycle 132.
  - Each in_valid=0 cycle during ISSUE adds exactly one cycle.
- Arithmetic: wgt_addr computed as unsigned with no wrap. pass*N_INPUTS is a constant offset. Max wgt_addr = 2*N_INPUTS-1 (123 for defaults).

Decomposition:
- Shared package nn_ctrl_pkg holds:
  - state enum: IDLE, CLR, ISSUE, DRAIN, LOAD, DONE;
  - HIDDEN_PASSES=2;
  - MACS_PER_PASS=10.
- No sub-module: a single FSM plus counters in one module.

Test Plan:
- Defaults, start pulsed in IDLE, in_valid=1 always:
  - acc_clr in cycles 1 and 67;
  - in_addr sweeps 0..61 during pass 0, with wgt_addr 0..61;
  - in pass 1, wgt_addr runs 62..123;
  - ld1 only in cycle 66, ld2 only in cycle 132, done only in cycle 133;
  - busy drops in cycle 134.
- in_valid=0 for 3 cycles at idx=10 of pass 0: in_addr holds at 10 with mac_en=0 for those cycles; ld1 moves to cycle 69 and done to cycle 136; total mac_en count = 124.
- start re-asserted in cycles 5, 70 and 133 (the DONE cycle): ignored. Exactly one ld1, one ld2 and one done; IDLE is reached in cycle 134.
- rst asserted in cycle 80, during pass 1 ISSUE: next cycle all outputs are 0 and busy=0; no ld2 or done. A fresh start then runs to done in 133 cycles.
- MAC_LAT=0, N_INPUTS=4:
  - DRAIN skipped;
  - ld1 in cycle 6, ld2 in cycle 12, done in cycle 13;
  - wgt_addr runs 0..3, then 4..7.
- ld1 and ld2 are never high together; mac_en is high only in ISSUE with in_valid=1; acc_clr is high in exactly 2 cycles per run.
